// File: rtl/beta_rd_ctrl.sv
// Read-side sequencer for the layered beta memory: issues P-wide beat reads and streams them out.
// Optional stall counter port stall_cnt when BETA_RD_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for a read request
// ISSUE | issuing beat reads as FIFO credit allows
// DRAIN | all beats issued, waiting for in-flight data and FIFO to empty
// ERR   | one-cycle illegal-layer pulse, no memory access
module beta_rd_ctrl #(
  parameter int P          = 16,
  parameter int Q          = 6,
  parameter int FIFO_DEPTH = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [4:0]     req_layer,
  input  logic [8:0]     req_addr,
  output logic [4:0]     ram_layer_r,
  output logic [5:0]     ram_cntb,
  output logic [8:0]     ram_r_address,
  output logic           ram_r_en,
  input  logic [P*Q-1:0] ram_b_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P*Q-1:0] out_data,
  output logic [5:0]     out_beat,
  output logic           out_last,
  output logic           busy,
  output logic           err_layer
`ifdef BETA_RD_PERF_EN
  ,output logic [15:0]   stall_cnt
`endif
);

  localparam int DW = P * Q;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [4:0]    layer_q, layer_d;
  logic [8:0]    addr_q, addr_d;
  logic [5:0]    beat_q, beat_d;
  logic [5:0]    last_beat_q, last_beat_d;
  logic          inflight_q, inflight_d;
  logic [5:0]    infl_beat_q, infl_beat_d;
  logic          infl_last_q, infl_last_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW:0]   used;
  logic          credit_ok;
  logic          push;
  logic          pop;
  logic          req_legal;

  logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
  logic [5:0]    fifo_beat_q [FIFO_DEPTH];
  logic          fifo_last_q [FIFO_DEPTH];

  function automatic logic [5:0] last_beat_of(input logic [4:0] l);
    case (l)
      5'd5:    return 6'd1;
      5'd6:    return 6'd3;
      5'd7:    return 6'd7;
      5'd8:    return 6'd15;
      default: return 6'd0;
    endcase
  endfunction

  // Credit counts the in-flight read so a push can never land on a full FIFO.
  assign used      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign credit_ok = used < (CW + 1)'(FIFO_DEPTH);
  assign ram_r_en  = (state_q == S_ISSUE) && credit_ok;

  assign req_legal = (req_layer != 5'd0) && (req_layer <= 5'd8);
  assign push      = inflight_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  assign req_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign err_layer     = (state_q == S_ERR);
  assign ram_layer_r   = layer_q;
  assign ram_r_address = addr_q;
  assign ram_cntb      = beat_q;

  assign out_data = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_beat = out_valid ? fifo_beat_q[rd_ptr_q] : '0;
  assign out_last = out_valid ? fifo_last_q[rd_ptr_q] : 1'b0;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    last_beat_d = last_beat_q;
    inflight_d  = ram_r_en;
    infl_beat_d = ram_r_en ? beat_q : infl_beat_q;
    infl_last_d = ram_r_en ? (beat_q == last_beat_q) : infl_last_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          layer_d     = req_layer;
          addr_d      = req_addr;
          beat_d      = 6'd0;
          last_beat_d = last_beat_of(req_layer);
          state_d     = req_legal ? S_ISSUE : S_ERR;
        end
      end
      S_ISSUE: begin
        if (ram_r_en) begin
          beat_d = beat_q + 6'd1;
          if (beat_q == last_beat_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Looks at the post-pop count so the final beat's pop returns us to IDLE.
        if (!inflight_q && (count_d == '0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      layer_q     <= '0;
      addr_q      <= '0;
      beat_q      <= '0;
      last_beat_q <= '0;
      inflight_q  <= 1'b0;
      infl_beat_q <= '0;
      infl_last_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      last_beat_q <= last_beat_d;
      inflight_q  <= inflight_d;
      infl_beat_q <= infl_beat_d;
      infl_last_q <= infl_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= ram_b_out;
      fifo_beat_q[wr_ptr_q] <= infl_beat_q;
      fifo_last_q[wr_ptr_q] <= infl_last_q;
    end
  end

`ifdef BETA_RD_PERF_EN
  logic [15:0] stall_q, stall_d;
  logic        stall_evt;

  always_comb begin
    stall_evt = (out_valid && !out_ready) || ((state_q == S_ISSUE) && !ram_r_en);
    stall_d   = stall_q;
    if (stall_evt && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_beta_rd_ctrl.sv
// Directed bench for beta_rd_ctrl with a 1-cycle-latency memory model and per-cycle logs.
module tb_beta_rd_ctrl;
  localparam int P  = 16;
  localparam int Q  = 6;
  localparam int DW = P * Q;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_layer;
  logic [8:0]    req_addr;
  logic [4:0]    ram_layer_r;
  logic [5:0]    ram_cntb;
  logic [8:0]    ram_r_address;
  logic          ram_r_en;
  logic [DW-1:0] ram_b_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [5:0]    out_beat;
  logic          out_last;
  logic          busy;
  logic          err_layer;
`ifdef BETA_RD_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  int checks;
  int failures;

  beta_rd_ctrl #(.P(P), .Q(Q), .FIFO_DEPTH(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_layer(req_layer), .req_addr(req_addr),
    .ram_layer_r(ram_layer_r), .ram_cntb(ram_cntb),
    .ram_r_address(ram_r_address), .ram_r_en(ram_r_en),
    .ram_b_out(ram_b_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_beat(out_beat), .out_last(out_last),
    .busy(busy), .err_layer(err_layer)
`ifdef BETA_RD_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [4:0] l, input logic [8:0] a,
                                             input logic [5:0] b);
    logic [DW-1:0] w;
    for (int i = 0; i < P; i++)
      w[i*Q +: Q] = 6'(int'(l) * 7 + int'(a) + int'(b) * 13 + i * 5);
    return w;
  endfunction

  // Memory model: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (ram_r_en) ram_b_out <= mem_word(ram_layer_r, ram_r_address, ram_cntb);
    else          ram_b_out <= {DW{1'b1}};
  end

  logic          en_log   [0:63];
  logic [5:0]    cntb_log [0:63];
  logic [8:0]    addr_log [0:63];
  logic [4:0]    lay_log  [0:63];
  logic          ov_log   [0:63];
  logic [5:0]    beat_log [0:63];
  logic          last_log [0:63];
  logic [DW-1:0] data_log [0:63];
  logic          rr_log   [0:63];
  logic          err_log  [0:63];
  logic          busy_log [0:63];
  logic          rdy_log  [0:63];

  task automatic log_cycle(input int c);
    en_log[c]   = ram_r_en;
    cntb_log[c] = ram_cntb;
    addr_log[c] = ram_r_address;
    lay_log[c]  = ram_layer_r;
    ov_log[c]   = out_valid;
    beat_log[c] = out_beat;
    last_log[c] = out_last;
    data_log[c] = out_data;
    rr_log[c]   = req_ready;
    err_log[c]  = err_layer;
    busy_log[c] = busy;
  endtask

  // Cycle 0 is the handshake cycle; out_ready is low for cycles lo_s..lo_e; rst is raised for the edge ending cycle rst_c.
  task automatic do_req(input logic [4:0] l, input logic [8:0] a, input int n,
                        input int lo_s, input int lo_e, input int rst_c);
    @(negedge clk);
    req_valid = 1'b1;
    req_layer = l;
    req_addr  = a;
    out_ready = 1'b1;
    log_cycle(0);
    rdy_log[0] = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      rst       = 1'b0;
      log_cycle(c);
      out_ready  = !(c >= lo_s && c <= lo_e);
      rdy_log[c] = out_ready;
      if (c == rst_c) rst = 1'b1;
    end
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
    checks++; if (ram_r_en !== 1'b0) begin failures++; $display("FAIL reset_r_en got %0b want 0", ram_r_en); end
    checks++; if (ram_cntb !== 6'd0 || ram_layer_r !== 5'd0 || ram_r_address !== 9'd0) begin
      failures++; $display("FAIL reset_ram_port got cntb=%0d layer=%0d addr=%0d want 0", ram_cntb, ram_layer_r, ram_r_address); end
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_beat !== 6'd0) begin
      failures++; $display("FAIL reset_out got valid=%0b last=%0b beat=%0d want 0", out_valid, out_last, out_beat); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (busy !== 1'b0 || err_layer !== 1'b0) begin
      failures++; $display("FAIL reset_busy_err got busy=%0b err=%0b want 0", busy, err_layer); end
    rst = 1'b0;
  endtask

  task automatic test_layer8_stream();
    logic exp_en, exp_ov;
    do_req(5'd8, 9'd0, 22, -1, -2, -1);
    checks++; if (rr_log[0] !== 1'b1) begin failures++; $display("FAIL l8_ready_c0 got %0b want 1", rr_log[0]); end
    checks++; if (lay_log[1] !== 5'd8) begin failures++; $display("FAIL l8_layer got %0d want 8", lay_log[1]); end
    for (int c = 1; c <= 22; c++) begin
      exp_en = (c <= 16);
      exp_ov = (c >= 3 && c <= 18);
      checks++; if (en_log[c] !== exp_en) begin failures++; $display("FAIL l8_r_en c%0d got %0b want %0b", c, en_log[c], exp_en); end
      if (exp_en) begin
        checks++; if (cntb_log[c] !== 6'(c - 1)) begin failures++; $display("FAIL l8_cntb c%0d got %0d want %0d", c, cntb_log[c], c - 1); end
      end
      checks++; if (ov_log[c] !== exp_ov) begin failures++; $display("FAIL l8_out_valid c%0d got %0b want %0b", c, ov_log[c], exp_ov); end
      if (exp_ov) begin
        checks++; if (beat_log[c] !== 6'(c - 3)) begin failures++; $display("FAIL l8_beat c%0d got %0d want %0d", c, beat_log[c], c - 3); end
        checks++; if (last_log[c] !== (c == 18)) begin failures++; $display("FAIL l8_last c%0d got %0b want %0b", c, last_log[c], (c == 18)); end
        checks++; if (data_log[c] !== mem_word(5'd8, 9'd0, 6'(c - 3))) begin
          failures++; $display("FAIL l8_data c%0d got %h want %h", c, data_log[c], mem_word(5'd8, 9'd0, 6'(c - 3))); end
      end
    end
    checks++; if (rr_log[18] !== 1'b0) begin failures++; $display("FAIL l8_ready_c18 got %0b want 0", rr_log[18]); end
    checks++; if (rr_log[19] !== 1'b1) begin failures++; $display("FAIL l8_ready_c19 got %0b want 1", rr_log[19]); end
  endtask

  task automatic test_single_beat();
    int nen, nov;
    nen = 0; nov = 0;
    do_req(5'd3, 9'd37, 8, -1, -2, -1);
    for (int c = 0; c <= 8; c++) begin
      if (en_log[c] === 1'b1) nen++;
      if (ov_log[c] === 1'b1) nov++;
    end
    checks++; if (nen != 1) begin failures++; $display("FAIL l3_issue_count got %0d want 1", nen); end
    checks++; if (en_log[1] !== 1'b1 || addr_log[1] !== 9'd37 || cntb_log[1] !== 6'd0 || lay_log[1] !== 5'd3) begin
      failures++; $display("FAIL l3_issue got en=%0b addr=%0d cntb=%0d layer=%0d want 1/37/0/3", en_log[1], addr_log[1], cntb_log[1], lay_log[1]); end
    checks++; if (nov != 1) begin failures++; $display("FAIL l3_out_count got %0d want 1", nov); end
    checks++; if (ov_log[3] !== 1'b1 || beat_log[3] !== 6'd0 || last_log[3] !== 1'b1) begin
      failures++; $display("FAIL l3_out got valid=%0b beat=%0d last=%0b want 1/0/1", ov_log[3], beat_log[3], last_log[3]); end
    checks++; if (data_log[3] !== mem_word(5'd3, 9'd37, 6'd0)) begin
      failures++; $display("FAIL l3_data got %h want %h", data_log[3], mem_word(5'd3, 9'd37, 6'd0)); end
  endtask

  task automatic test_backpressure();
    int early, nen, k;
    early = 0; nen = 0; k = 0;
    do_req(5'd6, 9'd100, 20, 3, 10, -1);
    for (int c = 1; c <= 20; c++) begin
      if (en_log[c] === 1'b1) begin
        nen++;
        if (c <= 11) early++;
      end
      if (ov_log[c] === 1'b1 && rdy_log[c] === 1'b1) begin
        checks++; if (beat_log[c] !== 6'(k)) begin failures++; $display("FAIL bp_beat_order c%0d got %0d want %0d", c, beat_log[c], k); end
        checks++; if (last_log[c] !== (k == 3)) begin failures++; $display("FAIL bp_last c%0d got %0b want %0b", c, last_log[c], (k == 3)); end
        checks++; if (data_log[c] !== mem_word(5'd6, 9'd100, 6'(k))) begin
          failures++; $display("FAIL bp_data c%0d got %h want %h", c, data_log[c], mem_word(5'd6, 9'd100, 6'(k))); end
        k++;
      end
    end
    checks++; if (early != 3) begin failures++; $display("FAIL bp_issues_before_pop got %0d want 3", early); end
    checks++; if (en_log[12] !== 1'b1 || cntb_log[12] !== 6'd3) begin
      failures++; $display("FAIL bp_fourth_issue got en=%0b cntb=%0d want 1/3", en_log[12], cntb_log[12]); end
    checks++; if (nen != 4) begin failures++; $display("FAIL bp_issue_total got %0d want 4", nen); end
    checks++; if (k != 4) begin failures++; $display("FAIL bp_beats_delivered got %0d want 4", k); end
  endtask

  task automatic test_err_layer();
    logic [4:0] bad [2];
    int nen, nov;
    bad[0] = 5'd0;
    bad[1] = 5'd9;
    for (int t = 0; t < 2; t++) begin
      nen = 0; nov = 0;
      do_req(bad[t], 9'd5, 5, -1, -2, -1);
      for (int c = 0; c <= 5; c++) begin
        if (en_log[c] === 1'b1) nen++;
        if (ov_log[c] === 1'b1) nov++;
      end
      checks++; if (err_log[0] !== 1'b0 || err_log[1] !== 1'b1 || err_log[2] !== 1'b0) begin
        failures++; $display("FAIL err_pulse layer%0d got %0b%0b%0b want 010", bad[t], err_log[0], err_log[1], err_log[2]); end
      checks++; if (nen != 0 || nov != 0) begin
        failures++; $display("FAIL err_no_access layer%0d got en=%0d ov=%0d want 0/0", bad[t], nen, nov); end
      checks++; if (rr_log[1] !== 1'b0 || rr_log[2] !== 1'b1) begin
        failures++; $display("FAIL err_ready layer%0d got c1=%0b c2=%0b want 0/1", bad[t], rr_log[1], rr_log[2]); end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    k = 0;
    do_req(5'd8, 9'd200, 12, -1, -2, 7);
    checks++; if (ov_log[7] !== 1'b1 || beat_log[7] !== 6'd4) begin
      failures++; $display("FAIL rm_fifth_beat got valid=%0b beat=%0d want 1/4", ov_log[7], beat_log[7]); end
    checks++; if (ov_log[8] !== 1'b0 || en_log[8] !== 1'b0 || rr_log[8] !== 1'b1 || busy_log[8] !== 1'b0) begin
      failures++; $display("FAIL rm_after_reset got ov=%0b en=%0b rr=%0b busy=%0b want 0/0/1/0", ov_log[8], en_log[8], rr_log[8], busy_log[8]); end
    checks++; if (ov_log[9] !== 1'b0 || ov_log[10] !== 1'b0) begin
      failures++; $display("FAIL rm_stale_push got c9=%0b c10=%0b want 0/0", ov_log[9], ov_log[10]); end
    do_req(5'd5, 9'd11, 8, -1, -2, -1);
    for (int c = 1; c <= 8; c++) begin
      if (ov_log[c] === 1'b1) begin
        checks++; if (beat_log[c] !== 6'(k) || last_log[c] !== (k == 1)) begin
          failures++; $display("FAIL rm_l5_beat c%0d got beat=%0d last=%0b want %0d/%0b", c, beat_log[c], last_log[c], k, (k == 1)); end
        checks++; if (data_log[c] !== mem_word(5'd5, 9'd11, 6'(k))) begin
          failures++; $display("FAIL rm_l5_data c%0d got %h want %h", c, data_log[c], mem_word(5'd5, 9'd11, 6'(k))); end
        k++;
      end
    end
    checks++; if (k != 2) begin failures++; $display("FAIL rm_l5_count got %0d want 2", k); end
  endtask

`ifdef BETA_RD_PERF_EN
  task automatic test_perf();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL perf_reset got %0d want 0", stall_cnt); end
    // Stalls: cycles 3..6 (output blocked) plus cycle 7 (FIFO full, no credit).
    do_req(5'd7, 9'd3, 16, 3, 6, -1);
    checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL perf_count got %0d want 5", stall_cnt); end
    @(negedge clk);
    req_valid = 1'b1; req_layer = 5'd7; req_addr = 9'd0; out_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (65600) @(negedge clk);
    checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL perf_saturate got %0d want 65535", stall_cnt); end
    @(negedge clk);
    checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL perf_hold got %0d want 65535", stall_cnt); end
    out_ready = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL perf_drain_idle got %0b want 1", req_ready); end
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_layer = '0;
    req_addr  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_layer8_stream();
    test_single_beat();
    test_backpressure();
    test_err_layer();
    test_reset_mid();
`ifdef BETA_RD_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
